// File: rtl/uart_tx_serial.sv
// uart_tx_serial: byte-stream UART transmitter with a small input FIFO.
// Each frame is a start bit, 8 data bits sent LSB first, an optional parity
// bit and one stop bit. Frames start only while cts_n is low.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   baud_div       clock cycles per bit (values < 2 act as 2), taken at frame start
//   in_data/in_valid/in_ready  byte input stream (in_ready = FIFO not full)
//   cts_n          active-low clear-to-send; high holds off the next frame
//   tx             serial line, idles high
//   busy           a frame is in progress
//   tx_irq         one-cycle pulse when the last queued frame has finished
//   level          FIFO occupancy
module uart_tx_serial #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PARITY = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              baud_div,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     cts_n,
   output logic                     tx,
   output logic                     busy,
   output logic                     tx_irq,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e         state_q, state_d;
   logic [7:0]     mem [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]  level_q, level_d;
   logic [7:0]     shift_q, shift_d;
   logic           par_q, par_d;
   logic [15:0]    div_q, div_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic           tx_q, tx_d;
   logic           busy_q, busy_d;
   logic           irq_pend_q, irq_q;
   logic           in_ready_q;

   logic           push, pop, irq_set;
   logic           bit_end, can_start;
   logic [7:0]     head;

   assign push      = in_valid && in_ready_q;
   assign bit_end   = (cnt_q == (div_q - 16'd1));
   assign can_start = (level_q != LW'(0)) && !cts_n;
   assign head      = mem[rd_ptr_q];

   // FIFO occupancy update
   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO storage (no reset needed on the data array)
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= in_data;
   end

   // FIFO pointers, level and ready
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q    <= level_d;
         in_ready_q <= (level_d != LW'(DEPTH));
      end
   end

   // State register and frame datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         par_q   <= 1'b0;
         div_q   <= 16'd2;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic; a frame start pops the head byte and latches the divisor
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      par_d   = par_q;
      div_d   = div_q;
      cnt_d   = cnt_q + 16'd1;
      idx_d   = idx_q;
      pop     = 1'b0;
      irq_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = cnt_q;
            if (can_start) begin
               pop     = 1'b1;
               shift_d = head;
               par_d   = ^head;
               div_d   = (baud_div < 16'd2) ? 16'd2 : baud_div;
               cnt_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain straight into the next frame when allowed, no idle gap
               if (can_start) begin
                  pop     = 1'b1;
                  shift_d = head;
                  par_d   = ^head;
                  div_d   = (baud_div < 16'd2) ? 16'd2 : baud_div;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
                  irq_set = (level_q == LW'(0));
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from current state; registered below
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_q != S_IDLE);
      case (state_q)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_q[0];
         S_PARITY: tx_d = (PARITY == 2) ? ~par_q : par_q;
         default:  tx_d = 1'b1;
      endcase
   end

   // Output registers; irq is delayed one extra stage so it lines up with busy falling
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         irq_pend_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         irq_pend_q <= irq_set;
         irq_q      <= irq_pend_q;
      end
   end

   assign tx       = tx_q;
   assign busy     = busy_q;
   assign tx_irq   = irq_q;
   assign in_ready = in_ready_q;
   assign level    = level_q;

endmodule

// File: tb/tb_uart_tx_serial.sv
// Testbench for uart_tx_serial: three instances (no parity, even, odd) share
// the stimulus; the one selected by `sel` is checked against a frame model.
module tb_uart_tx_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        cts_n;

   logic       tx0, tx1, tx2, busy0, busy1, busy2, irq0, irq1, irq2, rdy0, rdy1, rdy2;
   logic [2:0] lvl0, lvl1, lvl2;

   int         sel;
   logic       tx_s, busy_s, irq_s, rdy_s;
   logic [2:0] lvl_s;

   int errors = 0;
   int checks = 0;
   int irq_cnt = 0;
   int irq_base;

   int   wr_k, wr_max_lvl, wr_guard;
   bit   wr_acc, wr_saw_block;
   int   div_e;
   logic [7:0] rb;

   always #5 clk = ~clk;

   uart_tx_serial #(.DEPTH(4), .PARITY(0)) dut0 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .cts_n(cts_n), .tx(tx0), .busy(busy0), .tx_irq(irq0), .level(lvl0));
   uart_tx_serial #(.DEPTH(4), .PARITY(1)) dut1 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .cts_n(cts_n), .tx(tx1), .busy(busy1), .tx_irq(irq1), .level(lvl1));
   uart_tx_serial #(.DEPTH(4), .PARITY(2)) dut2 (
      .clk(clk), .rst(rst), .baud_div(baud_div), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy2), .cts_n(cts_n), .tx(tx2), .busy(busy2), .tx_irq(irq2), .level(lvl2));

   assign tx_s   = (sel == 1) ? tx1   : (sel == 2) ? tx2   : tx0;
   assign busy_s = (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy0;
   assign irq_s  = (sel == 1) ? irq1  : (sel == 2) ? irq2  : irq0;
   assign rdy_s  = (sel == 1) ? rdy1  : (sel == 2) ? rdy2  : rdy0;
   assign lvl_s  = (sel == 1) ? lvl1  : (sel == 2) ? lvl2  : lvl0;

   always @(negedge clk) if (irq_s === 1'b1) irq_cnt++;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One handshake; returns at the negedge right after the accepting edge
   task automatic send(input logic [7:0] b);
      int n = 0;
      while (rdy_s !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", 32'(rdy_s), 32'd1);
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Reference frame: bit k of the frame is held for div cycles
   task automatic expect_frame(input logic [7:0] b, input int div, input int pm,
                               input int cts_at, input int nmax, input bit scramble);
      logic [10:0] bits;
      int nb, len;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
      nb = (pm != 0) ? 11 : 10;
      if (pm == 1) bits[9] = ^b;
      else if (pm == 2) bits[9] = ~^b;
      len = nb * div;
      for (int j = 0; j < len && j < nmax; j++) begin
         @(negedge clk);
         if (j == cts_at) cts_n = 1'b1;
         if (scramble && j == 1) baud_div = 16'($urandom_range(0, 9));
         chk($sformatf("frame_tx b=%02h j=%0d", b, j), 32'(tx_s), 32'(bits[j/div]));
         chk($sformatf("frame_busy b=%02h j=%0d", b, j), 32'(busy_s), 32'd1);
      end
   endtask

   // Cycle after the final stop cycle: irq pulse with busy low
   task automatic expect_end(input string tag);
      @(negedge clk);
      chk({tag, "_irq"}, 32'(irq_s), 32'd1);
      chk({tag, "_busy"}, 32'(busy_s), 32'd0);
      chk({tag, "_tx"}, 32'(tx_s), 32'd1);
      @(negedge clk);
      chk({tag, "_irq_off"}, 32'(irq_s), 32'd0);
   endtask

   initial begin
      // Reset held 3 cycles with in_valid high
      sel = 0; rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; cts_n = 1'b0; baud_div = 16'd4;
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx_s), 32'd1);
         chk("rst_ready", 32'(rdy_s), 32'd1);
         chk("rst_level", 32'(lvl_s), 32'd0);
         chk("rst_busy", 32'(busy_s), 32'd0);
         chk("rst_irq", 32'(irq_s), 32'd0);
      end
      rst = 1'b0; in_valid = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("post_rst_tx", 32'(tx_s), 32'd1);
         chk("post_rst_level", 32'(lvl_s), 32'd0);
      end

      // Single byte 0xA5, div 4
      irq_base = irq_cnt;
      send(8'hA5);
      chk("single_level", 32'(lvl_s), 32'd1);
      @(negedge clk);
      chk("single_tx_pre", 32'(tx_s), 32'd1);
      expect_frame(8'hA5, 4, 0, -1, 1000, 1'b0);
      expect_end("single");
      @(negedge clk);
      chk("single_irq_count", 32'(irq_cnt - irq_base), 32'd1);

      // Back-to-back, six bytes, div 2, with backpressure
      baud_div = 16'd2;
      do_reset();
      irq_base = irq_cnt;
      fork
         begin
            wr_k = 0; wr_max_lvl = 0; wr_saw_block = 1'b0; wr_guard = 0;
            in_data = 8'h00; in_valid = 1'b1;
            while (wr_k < 6 && wr_guard < 500) begin
               wr_acc = (rdy_s === 1'b1);
               if (!wr_acc) wr_saw_block = 1'b1;
               @(negedge clk);
               wr_guard++;
               if (int'(lvl_s) > wr_max_lvl) wr_max_lvl = int'(lvl_s);
               if (wr_acc) begin
                  wr_k++;
                  in_data = 8'(wr_k);
               end
            end
            in_valid = 1'b0;
         end
         begin
            @(negedge clk);
            @(negedge clk);
            chk("b2b_tx_pre", 32'(tx_s), 32'd1);
            for (int b = 0; b < 6; b++) expect_frame(8'(b), 2, 0, -1, 1000, 1'b0);
         end
      join
      expect_end("b2b");
      repeat (3) @(negedge clk);
      chk("b2b_written", 32'(wr_k), 32'd6);
      chk("b2b_ready_dropped", 32'(wr_saw_block), 32'd1);
      chk("b2b_level_max", 32'(wr_max_lvl), 32'd4);
      chk("b2b_irq_count", 32'(irq_cnt - irq_base), 32'd1);

      // Flow control: hold off, release, re-raise mid-frame
      baud_div = 16'd4;
      do_reset();
      irq_base = irq_cnt;
      cts_n = 1'b1;
      send(8'h3C);
      send(8'h5A);
      chk("fc_level", 32'(lvl_s), 32'd2);
      repeat (50) begin
         @(negedge clk);
         chk("fc_hold_tx", 32'(tx_s), 32'd1);
      end
      cts_n = 1'b0;
      @(negedge clk);
      chk("fc_tx_pre", 32'(tx_s), 32'd1);
      expect_frame(8'h3C, 4, 0, 15, 1000, 1'b0);
      @(negedge clk);
      chk("fc_end_busy", 32'(busy_s), 32'd0);
      repeat (20) begin
         @(negedge clk);
         chk("fc_second_held", 32'(tx_s), 32'd1);
      end
      chk("fc_level_after", 32'(lvl_s), 32'd1);
      chk("fc_no_irq", 32'(irq_cnt - irq_base), 32'd0);
      cts_n = 1'b0;

      // Parity: even then odd
      sel = 1;
      do_reset();
      send(8'h07);
      @(negedge clk);
      expect_frame(8'h07, 4, 1, -1, 1000, 1'b0);
      expect_end("par_even_07");
      send(8'h03);
      @(negedge clk);
      expect_frame(8'h03, 4, 1, -1, 1000, 1'b0);
      expect_end("par_even_03");
      sel = 2;
      do_reset();
      send(8'h07);
      @(negedge clk);
      expect_frame(8'h07, 4, 2, -1, 1000, 1'b0);
      expect_end("par_odd_07");

      // Reset during data bit 3 discards frame and queue
      sel = 0;
      do_reset();
      send(8'h96);
      send(8'h11);
      expect_frame(8'h96, 4, 0, -1, 18, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_tx", 32'(tx_s), 32'd1);
      chk("mid_rst_level", 32'(lvl_s), 32'd0);
      chk("mid_rst_busy", 32'(busy_s), 32'd0);
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk);
         chk("mid_rst_idle_tx", 32'(tx_s), 32'd1);
      end
      chk("mid_rst_idle_level", 32'(lvl_s), 32'd0);

      // Divisor 0 behaves as 2
      baud_div = 16'd0;
      send(8'hFF);
      @(negedge clk);
      expect_frame(8'hFF, 2, 0, -1, 1000, 1'b0);
      expect_end("div0");

      // Random bytes and divisors on every parity variant; divisor scrambled mid-frame
      for (int s = 0; s < 3; s++) begin
         sel = s;
         do_reset();
         for (int f = 0; f < 4; f++) begin
            baud_div = 16'($urandom_range(0, 6));
            div_e    = (int'(baud_div) < 2) ? 2 : int'(baud_div);
            rb       = 8'($urandom);
            send(rb);
            @(negedge clk);
            chk("rnd_tx_pre", 32'(tx_s), 32'd1);
            expect_frame(rb, div_e, s, -1, 1000, 1'b1);
            expect_end("rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_serial.md
# uart_tx_serial

Standalone UART transmit engine: accepts bytes over a valid/ready stream, buffers them in a small FIFO and serializes them as 8-bit asynchronous frames (start, 8 data LSB first, optional parity, stop) on `tx`. It is the transmit counterpart of the serial receive path. It is used wherever a block needs to emit a UART byte stream: driving the UART peripheral's `rx` pin in system benches, or feeding an external host.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries. Power of two, ≥2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active-high.
- `baud_div` in 16: clock cycles per bit. Sampled only at frame start. Values < 2 are treated as 2.
- `in_data` in 8: byte to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: FIFO not full.
- `cts_n` in 1: clear-to-send, active-low. High blocks the start of a new frame.
- `tx` out 1: serial line. Idles high.
- `busy` out 1: a frame is in progress (state ≠ IDLE).
- `tx_irq` out 1: one-cycle pulse when the last queued frame finishes and the FIFO is empty.
- `level` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation

- **FIFO**
  - A write occurs when `in_valid && in_ready`.
  - A pop occurs at frame start.
  - Simultaneous write and pop on a full FIFO: the pop frees the slot, but `in_ready` is registered from the current level, so no write is accepted that cycle.
  - Simultaneous write and pop on a non-full FIFO: `level` is unchanged.
- **State machine**: IDLE, START, DATA, PARITY, STOP.
  - **IDLE**: `tx = 1`. If `level != 0` and `cts_n == 0`: pop the head byte into the shift register, latch `max(baud_div, 2)` into `div_q`, clear the baud counter, go to START.
  - **START**: `tx = 0` for `div_q` cycles, then go to DATA with bit index 0.
  - **DATA**: `tx = shift[0]`. Each bit lasts `div_q` cycles, then shift right and increment the index. After bit 7, go to PARITY if `PARITY != 0`, else STOP.
  - **PARITY**: `tx` = XOR of the 8 data bits (even), or its inverse (odd). Lasts `div_q` cycles.
  - **STOP**: `tx = 1` for `div_q` cycles. On the last cycle:
    - If `level != 0` and `cts_n == 0`: pop and go directly to START. No idle gap between frames.
    - Else go to IDLE. If `level == 0`, pulse `tx_irq`.
- **Baud counter** (16 bits): counts 0 to `div_q − 1`. The bit ends on the cycle the counter equals `div_q − 1`. `baud_div` changes mid-frame are ignored.
- **Flow control**: `cts_n` is checked only at frame-start decision points. Deasserting CTS mid-frame never aborts or stretches the frame.
- **Frame length**: 10·`div_q` cycles, or 11·`div_q` with parity.

## Timing

- **Reset values**: `tx = 1`, `busy = 0`, `tx_irq = 0`, `in_ready = 1`, `level = 0`. FIFO is emptied, state is IDLE.
- **Reset mid-frame**: the next cycle has `tx = 1`. The partial frame and all queued bytes are discarded.
- **Registered outputs**: `tx`, `busy`, `tx_irq`, `in_ready` and `level` are all registered.
- **Latency**: a byte written at edge N into an empty FIFO while idle with CTS low gives `level = 1` after N, the IDLE decision at N+1, and `tx = 0` after edge N+2.
- **`tx_irq` timing**: asserts the cycle after the final stop-bit cycle, together with `busy` falling.
- **CTS sampling**: `cts_n` is used synchronously and is not synchronized internally. The integrator provides a synchronizer for asynchronous sources.

## Test plan

- **Reset**: hold `rst` for 3 cycles with `in_valid = 1`. Require `tx = 1`, `in_ready = 1`, `level = 0` during and after reset, and nothing transmitted.
- **Single byte**: `baud_div = 4`, `PARITY = 0`, write 0xA5 with `cts_n = 0`.
  - `tx` falls 2 cycles after the write.
  - Sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; 40 cycles total.
  - `tx_irq` pulses once at the end.
- **Back-to-back and backpressure**: `DEPTH = 4`, `baud_div = 2`, write 6 bytes 0x00–0x05 continuously.
  - `in_ready` drops after 4 are queued beyond the one in flight.
  - All 6 frames are contiguous, with no idle cycle between stop and start.
  - Exactly one `tx_irq`.
- **Flow control**: `cts_n = 1`, write 0x3C. Require `tx` to stay 1 for 50 cycles. Lower `cts_n`; the frame starts 1 cycle later. Raise `cts_n` mid-frame; the frame completes intact.
- **Parity**: `PARITY = 1`, send 0x07 (parity bit 1) and 0x03 (parity bit 0). `PARITY = 2`, send 0x07 (parity bit 0). Frame length is 11·`div_q`.
- **Reset mid-frame and divisor edge**: assert `rst` during DATA bit 3; `tx = 1` next cycle and `level = 0`. Then set `baud_div = 0` and send 0xFF; each bit lasts 2 cycles.
